mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: cycles from a memory issue cycle to valid mem_rdata (legal range 1..15).
REQ-002 Parameter STARVE_MAX, default 4: consecutive data grants tolerated while fetch waits (legal range 1..15).
REQ-003 clock  in  1  system clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  instruction-fetch request.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_gnt  out  1  fetch request accepted (one-cycle pulse).
REQ-008 if_rvalid  out  1  fetch complete, if_rdata valid (one-cycle pulse).
REQ-009 if_rdata  out  32  fetched word.
REQ-010 dm_req  in  1  data-memory request.
REQ-011 dm_we  in  1  1 = write, 0 = read.
REQ-012 dm_addr  in  32  data byte address.
REQ-013 dm_wdata  in  32  write data.
REQ-014 dm_gnt  out  1  data request accepted (one-cycle pulse).
REQ-015 dm_rvalid  out  1  data access complete (one-cycle pulse; reads and writes).
REQ-016 dm_rdata  out  32  read word.
REQ-017 mem_en  out  1  single-port memory access strobe.
REQ-018 mem_we  out  1  memory write enable, qualified by mem_en.
REQ-019 mem_addr  out  32  memory address.
REQ-020 mem_wdata  out  32  memory write data.
REQ-021 mem_rdata  in  32  memory read data, valid MEM_LAT cycles after the issue cycle.
REQ-022 busy  out  1  high whenever state is not IDLE.

Function
REQ-023 The block SHALL share one single-port memory between fetch and data requesters, with at most one outstanding access.
REQ-024 States SHALL be IDLE, ISSUE, WAIT, DONE; arbitration occurs only at the clock edge ending an IDLE or DONE cycle.
REQ-025 Arbitration: if only one req is high, that requester wins; if both are high, dm wins unless starve_cnt == STARVE_MAX, in which case if wins.
REQ-026 Arbitration with a winner SHALL latch owner, address, we (0 for fetch) and wdata, then enter ISSUE; with no req it SHALL enter or stay in IDLE.
REQ-027 ISSUE (exactly 1 cycle): mem_en=1, mem_we=latched we, gnt of owner=1; then WAIT.
REQ-028 WAIT SHALL last exactly MEM_LAT cycles, tracked by a cycle counter; mem_en=0.
REQ-029 At the edge ending the last WAIT cycle, for a read, mem_rdata SHALL be captured into the owner's rdata register; then DONE.
REQ-030 DONE (1 cycle): owner's rvalid=1; rdata is stable from DONE until the owner's next read capture.
REQ-031 Writes SHALL leave dm_rdata unchanged; if_rdata changes only on fetch completion.
REQ-032 mem_addr and mem_wdata SHALL present latched values from ISSUE through the last WAIT cycle, and SHALL hold those values in IDLE and DONE.
REQ-033 Latency: req sampled at edge ending cycle N gives gnt in N+1 and rvalid in N+MEM_LAT+2; back-to-back issue period is MEM_LAT+2 cycles.
REQ-034 starve_cnt (4 bits) SHALL increment, saturating at STARVE_MAX, when dm wins while if_req is high.
REQ-035 starve_cnt SHALL clear when fetch wins, and SHALL hold otherwise.
REQ-036 Requesters SHALL hold req, addr, we and wdata stable until gnt, and SHALL deassert req the cycle after gnt unless requesting again.
REQ-037 A req that drops before being granted SHALL be forgotten without side effects; req changes during ISSUE and WAIT are ignored.
REQ-038 At most one of if_gnt/dm_gnt and at most one of if_rvalid/dm_rvalid SHALL be high in any cycle.

Reset
REQ-039 While reset is high at a clock edge, state SHALL become IDLE; starve_cnt, the wait counter, if_rdata, dm_rdata, mem_addr and mem_wdata SHALL become 0.
REQ-040 After reset, all gnt, rvalid, mem_en and mem_we outputs SHALL be 0.
REQ-041 Reset mid-transaction SHALL abort the access with no rvalid, and no further mem_en until a new arbitration.
REQ-042 Requests present during reset SHALL be ignored; the first arbitration is the edge ending the first cycle with reset low.

Verification
REQ-043 Fetch read, MEM_LAT=2: if_req=1, if_addr=0x40 sampled at edge ending cycle 0 -> cycle 1: mem_en=1, mem_addr=0x40, if_gnt=1; memory returns 0x8C220004 in cycle 3 -> cycle 4: if_rvalid=1, if_rdata=0x8C220004.
REQ-044 Data write: dm_req=1, dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF -> ISSUE cycle shows mem_en=1, mem_we=1 with those values; dm_rvalid 3 cycles later; dm_rdata unchanged.
REQ-045 Contention, STARVE_MAX=4: both reqs held continuously, dm re-requesting after each gnt -> grant order dm,dm,dm,dm,if,dm,... and never two gnts in one cycle.
REQ-046 Reset mid-transaction: reset asserted during a WAIT cycle -> next cycle busy=0, no rvalid ever appears for that access, rdata registers=0.
REQ-047 Withdrawn request: dm_req pulses during WAIT of a fetch and drops before DONE -> no dm_gnt, no second mem_en.
REQ-048 MEM_LAT=1 back-to-back dm reads -> issue period 3 cycles; each dm_rdata matches mem_rdata from the cycle after its issue.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester and memory signals of the fetch/data memory arbiter.
// slave: the arbiter's view. master: the requesters' and memory's view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// one outstanding access at a time, with starvation protection for fetch.
//
// state | meaning
// IDLE  | no access in flight; arbitrate at end of cycle
// ISSUE | memory strobe and grant to the owner (1 cycle)
// WAIT  | memory latency, MEM_LAT cycles; read data captured on the last
// DONE  | owner's rvalid (1 cycle); arbitrate at end of cycle
module mem_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state, state_next;
    logic        owner_dm;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] dm_rdata_q;
    logic [3:0]  wait_cnt;
    logic [3:0]  starve_cnt;
    logic        arb_slot;
    logic        grant;
    logic        pick_dm;
    logic        last_wait;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        arb_slot   = (state == IDLE) || (state == DONE);
        grant      = arb_slot && (bus.if_req || bus.dm_req);
        // data wins a tie unless fetch has already been passed over STARVE_MAX times
        pick_dm    = bus.dm_req && (!bus.if_req || (starve_cnt != STARVE_LIM));
        last_wait  = (state == WAIT) && (wait_cnt == 4'd0);
        state_next = state;
        case (state)
            IDLE, DONE: state_next = grant ? ISSUE : IDLE;
            ISSUE:      state_next = WAIT;
            WAIT:       if (wait_cnt == 4'd0) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_dm   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            if (grant) begin
                owner_dm <= pick_dm;
                we_q     <= pick_dm && bus.dm_we;
                addr_q   <= pick_dm ? bus.dm_addr : bus.if_addr;
                if (pick_dm) wdata_q <= bus.dm_wdata;
                if (!pick_dm)
                    starve_cnt <= '0;
                else if (bus.if_req && (starve_cnt != STARVE_LIM))
                    starve_cnt <= starve_cnt + 4'd1;
            end

            if (state == ISSUE)
                wait_cnt <= LAT_LOAD;
            else if ((state == WAIT) && (wait_cnt != 4'd0))
                wait_cnt <= wait_cnt - 4'd1;

            if (last_wait && !we_q) begin
                if (owner_dm) dm_rdata_q <= bus.mem_rdata;
                else          if_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_gnt    = (state == ISSUE) && !owner_dm;
    assign bus.dm_gnt    = (state == ISSUE) &&  owner_dm;
    assign bus.if_rvalid = (state == DONE)  && !owner_dm;
    assign bus.dm_rvalid = (state == DONE)  &&  owner_dm;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_en    = (state == ISSUE);
    assign bus.mem_we    = (state == ISSUE) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table on a MEM_LAT=2
// instance, then contention and MEM_LAT=1 back-to-back sequences.
module tb_mem_arbiter;
    logic clock = 1'b0;
    logic rst2  = 1'b1;
    logic rst1  = 1'b1;
    logic busy2, busy1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clock = ~clock;

    mem_arbiter_if b2 ();
    mem_arbiter_if b1 ();

    mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) u_lat2 (
        .clock(clock), .reset(rst2), .bus(b2.slave), .busy(busy2)
    );
    mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
        .clock(clock), .reset(rst1), .bus(b1.slave), .busy(busy1)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8C22_0044;
    endfunction

    // memory returns its word only in the exact cycle MEM_LAT after the issue
    logic [32:0] p2_0 = '0, p2_1 = '0, p1_0 = '0;
    always @(posedge clock) begin
        p2_0 <= {b2.mem_en, b2.mem_addr};
        p2_1 <= p2_0;
        p1_0 <= {b1.mem_en, b1.mem_addr};
    end
    assign b2.mem_rdata = p2_1[32] ? mem_word(p2_1[31:0]) : 32'hBAD0_BAD0;
    assign b1.mem_rdata = p1_0[32] ? mem_word(p1_0[31:0]) : 32'hBAD0_BAD0;

    typedef struct {
        logic rst; logic ir; logic [31:0] ia;
        logic dr; logic dw; logic [31:0] da; logic [31:0] dd;
        logic ig; logic dg; logic iv; logic dv; logic en; logic we; logic bz;
        logic [31:0] ad; logic [31:0] ird; logic [31:0] drd;
        logic wc; logic [31:0] wd;
    } vec_t;

    localparam logic [31:0] I0 = 32'h8C22_0004;
    localparam logic [31:0] I1 = 32'h8C22_00C4;
    localparam logic [31:0] D0 = 32'h8C22_0064;
    localparam logic [31:0] W  = 32'hDEAD_BEEF;

    vec_t tbl [26];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int gwho [6];
    int gcyc [6];
    int exp_who [6];
    int icyc [3];
    int ng, both, issued, done;
    logic g;

    initial begin
        //         rst ir ia      dr dw da      dd   ig dg iv dv en we bz ad      ird drd  wc wd
        tbl[0]  = '{1, 1, 32'h40, 0, 0, 32'h0,  0,   0, 0, 0, 0, 0, 0, 0, 32'h0,   0,  0,  0, 0};
        tbl[1]  = '{0, 1, 32'h40, 0, 0, 32'h0,  0,   0, 0, 0, 0, 0, 0, 0, 32'h0,   0,  0,  0, 0};
        tbl[2]  = '{0, 1, 32'h40, 0, 0, 32'h0,  0,   1, 0, 0, 0, 1, 0, 1, 32'h40,  0,  0,  0, 0};
        tbl[3]  = '{0, 0, 32'h0,  0, 0, 32'h0,  0,   0, 0, 0, 0, 0, 0, 1, 32'h40,  0,  0,  0, 0};
        tbl[4]  = '{0, 0, 32'h0,  0, 0, 32'h0,  0,   0, 0, 0, 0, 0, 0, 1, 32'h40,  0,  0,  0, 0};
        tbl[5]  = '{0, 0, 32'h0,  1, 1, 32'h10, W,   0, 0, 1, 0, 0, 0, 1, 32'h40,  I0, 0,  0, 0};
        tbl[6]  = '{0, 0, 32'h0,  1, 1, 32'h10, W,   0, 1, 0, 0, 1, 1, 1, 32'h10,  I0, 0,  1, W};
        tbl[7]  = '{0, 0, 32'h0,  0, 0, 32'h0,  0,   0, 0, 0, 0, 0, 0, 1, 32'h10,  I0, 0,  1, W};
        tbl[8]  = '{0, 0, 32'h0,  0, 0, 32'h0,  0,   0, 0, 0, 0, 0, 0, 1, 32'h10,  I0, 0,  1, W};
        tbl[9]  = '{0, 0, 32'h0,  0, 0, 32'h0,  0,   0, 0, 0, 1, 0, 0, 1, 32'h10,  I0, 0,  1, W};
        tbl[10] = '{0, 1, 32'h80, 0, 0, 32'h0,  0,   0, 0, 0, 0, 0, 0, 0, 32'h10,  I0, 0,  1, W};
        tbl[11] = '{0, 1, 32'h80, 0, 0, 32'h0,  0,   1, 0, 0, 0, 1, 0, 1, 32'h80,  I0, 0,  0, 0};
        tbl[12] = '{0, 0, 32'h0,  1, 0, 32'h20, 0,   0, 0, 0, 0, 0, 0, 1, 32'h80,  I0, 0,  0, 0};
        tbl[13] = '{0, 0, 32'h0,  0, 0, 32'h0,  0,   0, 0, 0, 0, 0, 0, 1, 32'h80,  I0, 0,  0, 0};
        tbl[14] = '{0, 0, 32'h0,  0, 0, 32'h0,  0,   0, 0, 1, 0, 0, 0, 1, 32'h80,  I1, 0,  0, 0};
        tbl[15] = '{0, 0, 32'h0,  0, 0, 32'h0,  0,   0, 0, 0, 0, 0, 0, 0, 32'h80,  I1, 0,  0, 0};
        tbl[16] = '{0, 0, 32'h0,  1, 0, 32'h20, 0,   0, 0, 0, 0, 0, 0, 0, 32'h80,  I1, 0,  0, 0};
        tbl[17] = '{0, 0, 32'h0,  1, 0, 32'h20, 0,   0, 1, 0, 0, 1, 0, 1, 32'h20,  I1, 0,  0, 0};
        tbl[18] = '{0, 0, 32'h0,  0, 0, 32'h0,  0,   0, 0, 0, 0, 0, 0, 1, 32'h20,  I1, 0,  0, 0};
        tbl[19] = '{0, 0, 32'h0,  0, 0, 32'h0,  0,   0, 0, 0, 0, 0, 0, 1, 32'h20,  I1, 0,  0, 0};
        tbl[20] = '{0, 1, 32'h100,0, 0, 32'h0,  0,   0, 0, 0, 1, 0, 0, 1, 32'h20,  I1, D0, 0, 0};
        tbl[21] = '{0, 1, 32'h100,0, 0, 32'h0,  0,   1, 0, 0, 0, 1, 0, 1, 32'h100, I1, D0, 0, 0};
        tbl[22] = '{1, 0, 32'h0,  0, 0, 32'h0,  0,   0, 0, 0, 0, 0, 0, 1, 32'h100, I1, D0, 0, 0};
        tbl[23] = '{0, 0, 32'h0,  0, 0, 32'h0,  0,   0, 0, 0, 0, 0, 0, 0, 32'h0,   0,  0,  0, 0};
        tbl[24] = '{0, 0, 32'h0,  0, 0, 32'h0,  0,   0, 0, 0, 0, 0, 0, 0, 32'h0,   0,  0,  0, 0};
        tbl[25] = '{0, 0, 32'h0,  0, 0, 32'h0,  0,   0, 0, 0, 0, 0, 0, 0, 32'h0,   0,  0,  0, 0};

        exp_who = '{1, 1, 1, 1, 0, 1};
        for (int k = 0; k < 6; k++) begin gwho[k] = -1; gcyc[k] = -100; end
        for (int k = 0; k < 3; k++) icyc[k] = -100;

        b2.if_req = 0; b2.if_addr = 0; b2.dm_req = 0; b2.dm_we = 0; b2.dm_addr = 0; b2.dm_wdata = 0;
        b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = 0; b1.dm_wdata = 0;
        repeat (2) tick();

        for (int i = 0; i < 26; i++) begin
            rst2 = tbl[i].rst;
            b2.if_req = tbl[i].ir; b2.if_addr = tbl[i].ia;
            b2.dm_req = tbl[i].dr; b2.dm_we = tbl[i].dw;
            b2.dm_addr = tbl[i].da; b2.dm_wdata = tbl[i].dd;
            @(negedge clock);
            check($sformatf("vec%0d gnt/rv/en/we/busy/addr/irdata/drdata", i),
                  {25'd0, b2.if_gnt, b2.dm_gnt, b2.if_rvalid, b2.dm_rvalid, b2.mem_en,
                   b2.mem_we, busy2, b2.mem_addr, b2.if_rdata, b2.dm_rdata},
                  {25'd0, tbl[i].ig, tbl[i].dg, tbl[i].iv, tbl[i].dv, tbl[i].en,
                   tbl[i].we, tbl[i].bz, tbl[i].ad, tbl[i].ird, tbl[i].drd});
            if (tbl[i].wc)
                check($sformatf("vec%0d mem_wdata", i), {96'd0, b2.mem_wdata}, {96'd0, tbl[i].wd});
            tick();
        end

        // contention: both requesters hold req high continuously
        b2.if_req = 1; b2.if_addr = 32'h200;
        b2.dm_req = 1; b2.dm_we = 0; b2.dm_addr = 32'h300;
        ng = 0; both = 0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            @(negedge clock);
            if (b2.if_gnt && b2.dm_gnt) both++;
            if (b2.if_gnt || b2.dm_gnt) begin
                gwho[ng] = b2.dm_gnt ? 1 : 0;
                gcyc[ng] = c;
                ng++;
            end
            tick();
        end
        b2.if_req = 0; b2.dm_req = 0;
        check("cont grant count", 128'(ng), 128'(6));
        check("cont double grant cycles", 128'(both), 128'(0));
        check("cont first grant cycle", 128'(gcyc[0]), 128'(1));
        for (int k = 0; k < 6; k++)
            check($sformatf("cont grant%0d owner(1=dm)", k), 128'(gwho[k]), 128'(exp_who[k]));
        for (int k = 1; k < 6; k++)
            check($sformatf("cont period%0d", k), 128'(gcyc[k] - gcyc[k-1]), 128'(4));
        repeat (6) tick();

        // MEM_LAT=1 back-to-back data reads
        rst1 = 0;
        tick();
        @(negedge clock);
        check("lat1 busy after reset", {127'd0, busy1}, 128'd0);
        tick();
        b1.dm_req = 1; b1.dm_we = 0; b1.dm_addr = 32'h400;
        issued = 0; done = 0;
        for (int c = 0; c < 40 && done < 3; c++) begin
            @(negedge clock);
            g = b1.dm_gnt;
            if (g && issued < 3) begin icyc[issued] = c; issued++; end
            if (b1.dm_rvalid && done < 3) begin
                check($sformatf("lat1 read%0d dm_rdata", done), {96'd0, b1.dm_rdata},
                      {96'd0, mem_word(32'h400 + 32'(4 * done))});
                done++;
            end
            tick();
            if (g) begin
                if (issued == 3) b1.dm_req = 0;
                else b1.dm_addr = 32'h400 + 32'(4 * issued);
            end
        end
        b1.dm_req = 0;
        check("lat1 completions", 128'(done), 128'(3));
        check("lat1 period1", 128'(icyc[1] - icyc[0]), 128'(3));
        check("lat1 period2", 128'(icyc[2] - icyc[1]), 128'(3));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
